// File: rtl/regfile_writeback_if.sv
// Handshake bundle between execute/memory result producers, the writeback queue and the register file write port.
interface regfile_writeback_if #(
  parameter int unsigned XLEN = 64
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_value;

  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_value;

  logic            write_enable;
  logic [4:0]      write_register;
  logic [XLEN-1:0] write_value;
  logic            write_ready;

  // The writeback queue is the master: it accepts results and drives the write port.
  modport master (
    input  alu_valid, alu_rd, alu_value,
    output alu_ready,
    input  mem_valid, mem_rd, mem_value,
    output mem_ready,
    output write_enable, write_register, write_value,
    input  write_ready
  );

  modport slave (
    output alu_valid, alu_rd, alu_value,
    input  alu_ready,
    output mem_valid, mem_rd, mem_value,
    input  mem_ready,
    input  write_enable, write_register, write_value,
    output write_ready
  );
endinterface

// File: rtl/regfile_writeback.sv
// In-order writeback queue feeding the register file write port from ALU and load results.
// Optional macro BYPASS_EN adds youngest-pending-value lookup ports (hit1/hit2, hit_val1/hit_val2).
module regfile_writeback #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic                clk,
  input  logic                reset,
  regfile_writeback_if.master bus,
  input  logic [4:0]          lookup_reg1,
  input  logic [4:0]          lookup_reg2,
  output logic                hit1,
  output logic                hit2,
  output logic [XLEN-1:0]     hit_val1,
  output logic [XLEN-1:0]     hit_val2,
  output logic                empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE_FREE = CNT_W'(DEPTH - 1);

  logic [4:0]      rd_mem  [DEPTH];
  logic [XLEN-1:0] val_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] alu_slot;
  logic [CNT_W-1:0] count;

  logic mem_push;
  logic alu_push;
  logic pop;

  // Readiness ignores this cycle's pop so acceptance never depends on write_ready.
  always_comb begin
    empty         = (count == '0);
    bus.mem_ready = (count != CNT_FULL);
    bus.alu_ready = (count < CNT_ONE_FREE) | ((count == CNT_ONE_FREE) & ~bus.mem_valid);

    mem_push = bus.mem_valid & bus.mem_ready & (bus.mem_rd != '0);
    alu_push = bus.alu_valid & bus.alu_ready & (bus.alu_rd != '0);
    alu_slot = wr_ptr + PTR_W'(mem_push);

    pop                = ~empty & bus.write_ready;
    bus.write_enable   = pop;
    bus.write_register = empty ? '0 : rd_mem[rd_ptr];
    bus.write_value    = empty ? '0 : val_mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(mem_push) + PTR_W'(alu_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end
  end

  // Load lands first so it is older than a same-cycle ALU result.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      rd_mem[wr_ptr]  <= bus.mem_rd;
      val_mem[wr_ptr] <= bus.mem_value;
    end
    if (alu_push) begin
      rd_mem[alu_slot]  <= bus.alu_rd;
      val_mem[alu_slot] <= bus.alu_value;
    end
  end

`ifdef BYPASS_EN
  // Scan oldest to youngest so the last match is the youngest pending value.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    hit1     = 1'b0;
    hit2     = 1'b0;
    hit_val1 = '0;
    hit_val2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if ((lookup_reg1 != '0) && (rd_mem[idx] == lookup_reg1)) begin
          hit1     = 1'b1;
          hit_val1 = val_mem[idx];
        end
        if ((lookup_reg2 != '0) && (rd_mem[idx] == lookup_reg2)) begin
          hit2     = 1'b1;
          hit_val2 = val_mem[idx];
        end
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{lookup_reg1, lookup_reg2};
  assign hit1     = 1'b0;
  assign hit2     = 1'b0;
  assign hit_val1 = '0;
  assign hit_val2 = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: queue-based reference model plus directed literal checks.
module tb_regfile_writeback;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 64;

  logic            clk;
  logic            reset;
  logic [4:0]      lookup_reg1;
  logic [4:0]      lookup_reg2;
  logic            hit1, hit2;
  logic [XLEN-1:0] hit_val1, hit_val2;
  logic            empty;

  regfile_writeback_if #(.XLEN(XLEN)) bus ();

  regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .lookup_reg1 (lookup_reg1),
    .lookup_reg2 (lookup_reg2),
    .hit1        (hit1),
    .hit2        (hit2),
    .hit_val1    (hit_val1),
    .hit_val2    (hit_val2),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  logic            obs_ar, obs_mr, obs_we, obs_empty, obs_hit1;
  logic [4:0]      obs_reg;
  logic [XLEN-1:0] obs_val, obs_hv1;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic lookup(input logic [4:0] l, output logic h, output logic [XLEN-1:0] v);
    h = 1'b0;
    v = '0;
`ifdef BYPASS_EN
    foreach (q[i]) begin
      if (l != 0 && q[i].rd == l) begin
        h = 1'b1;
        v = q[i].val;
      end
    end
`endif
  endtask

  // Compare every output against the model, then advance the model to the next cycle.
  task automatic compare_model();
    int f;
    logic e_mr, e_ar, e_we, e_h1, e_h2;
    logic [4:0] e_reg;
    logic [XLEN-1:0] e_val, e_v1, e_v2;
    ent_t ent;
    f     = int'(DEPTH) - q.size();
    e_mr  = (f >= 1);
    e_ar  = (f >= 2) || (f == 1 && !bus.mem_valid);
    e_we  = (q.size() > 0) && bus.write_ready;
    e_reg = (q.size() > 0) ? q[0].rd : 5'd0;
    e_val = (q.size() > 0) ? q[0].val : '0;
    lookup(lookup_reg1, e_h1, e_v1);
    lookup(lookup_reg2, e_h2, e_v2);

    check("mem_ready", 64'(bus.mem_ready), 64'(e_mr));
    check("alu_ready", 64'(bus.alu_ready), 64'(e_ar));
    check("write_enable", 64'(bus.write_enable), 64'(e_we));
    check("write_register", 64'(bus.write_register), 64'(e_reg));
    check("write_value", bus.write_value, e_val);
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("hit1", 64'(hit1), 64'(e_h1));
    check("hit2", 64'(hit2), 64'(e_h2));
    check("hit_val1", hit_val1, e_v1);
    check("hit_val2", hit_val2, e_v2);

    obs_ar = bus.alu_ready; obs_mr = bus.mem_ready; obs_we = bus.write_enable;
    obs_empty = empty; obs_reg = bus.write_register; obs_val = bus.write_value;
    obs_hit1 = hit1; obs_hv1 = hit_val1;

    if (e_we) void'(q.pop_front());
    if (bus.mem_valid && e_mr && bus.mem_rd != 0) begin
      ent.rd = bus.mem_rd; ent.val = bus.mem_value; q.push_back(ent);
    end
    if (bus.alu_valid && e_ar && bus.alu_rd != 0) begin
      ent.rd = bus.alu_rd; ent.val = bus.alu_value; q.push_back(ent);
    end
  endtask

  task automatic cycle(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] aval,
                       input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] mval,
                       input logic wr, input logic [4:0] l1, input logic [4:0] l2);
    @(negedge clk);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_value = aval;
    bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_value = mval;
    bus.write_ready = wr;
    lookup_reg1 = l1; lookup_reg2 = l2;
    #2;
    compare_model();
  endtask

  task automatic idle(input logic wr, input logic [4:0] l1);
    cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, wr, l1, 5'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && q.size() > 0; n++) idle(1'b1, 5'd0);
    check("drain_bound", 64'(q.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.write_ready = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("rst_write_enable", 64'(bus.write_enable), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_write_value", bus.write_value, 64'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_value = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_value = '0;
    bus.write_ready = 1'b1;
    lookup_reg1 = '0; lookup_reg2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_we", 64'(bus.write_enable), 64'd0);
    check("reset_wreg", 64'(bus.write_register), 64'd0);
    check("reset_wval", bus.write_value, 64'd0);
    check("reset_hit1", 64'(hit1), 64'd0);
    @(negedge clk) reset = 1'b1;

    // Single ALU write
    cycle(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);
    check("t1_alu_ready", 64'(obs_ar), 64'd1);
    check("t1_no_same_cycle_write", 64'(obs_we), 64'd0);
    idle(1'b1, 5'd0);
    check("t1_we", 64'(obs_we), 64'd1);
    check("t1_reg", 64'(obs_reg), 64'd5);
    check("t1_val", obs_val, 64'hDEAD);
    idle(1'b1, 5'd0);
    check("t1_empty_after", 64'(obs_empty), 64'd1);

    // Dual accept, load older
    cycle(1'b1, 5'd3, 64'h22, 1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 5'd0);
    check("t2_both_ready", 64'({obs_mr, obs_ar}), 64'd3);
    idle(1'b0, 5'd3);
`ifdef BYPASS_EN
    check("t2_hit1", 64'(obs_hit1), 64'd1);
    check("t2_hit_val1", obs_hv1, 64'h22);
`else
    check("t2_hit1_tied", 64'(obs_hit1), 64'd0);
`endif
    idle(1'b1, 5'd0);
    check("t2_first", obs_val, 64'h11);
    idle(1'b1, 5'd0);
    check("t2_second", obs_val, 64'h22);
    check("t2_second_reg", 64'(obs_reg), 64'd3);

    // Fill and backpressure
    cycle(1'b1, 5'd2, 64'hA2, 1'b1, 5'd1, 64'hA1, 1'b0, 5'd0, 5'd0);
    cycle(1'b1, 5'd4, 64'hA4, 1'b1, 5'd3, 64'hA3, 1'b0, 5'd0, 5'd0);
    idle(1'b0, 5'd0);
    check("t3_full_mr", 64'(obs_mr), 64'd0);
    check("t3_full_ar", 64'(obs_ar), 64'd0);
    idle(1'b1, 5'd0);
    check("t3_w1", obs_val, 64'hA1);
    check("t3_pop_not_credited", 64'(obs_mr), 64'd0);
    idle(1'b1, 5'd0);
    check("t3_w2", obs_val, 64'hA2);
    check("t3_mr_back", 64'(obs_mr), 64'd1);
    idle(1'b1, 5'd0);
    check("t3_w3", obs_val, 64'hA3);
    idle(1'b1, 5'd0);
    check("t3_w4", obs_val, 64'hA4);

    // One free slot, load wins
    cycle(1'b1, 5'd8, 64'hB2, 1'b1, 5'd7, 64'hB1, 1'b0, 5'd0, 5'd0);
    cycle(1'b1, 5'd9, 64'hB3, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
    cycle(1'b1, 5'd11, 64'hB5, 1'b1, 5'd10, 64'hB4, 1'b0, 5'd0, 5'd0);
    check("t4_mr", 64'(obs_mr), 64'd1);
    check("t4_ar", 64'(obs_ar), 64'd0);
    cycle(1'b1, 5'd11, 64'hB5, 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);
    check("t4_ar_full", 64'(obs_ar), 64'd0);
    cycle(1'b1, 5'd11, 64'hB5, 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);
    check("t4_ar_slot", 64'(obs_ar), 64'd1);
    check("t4_w2", obs_val, 64'hB2);
    drain();

    // x0 drop
    cycle(1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0);
    check("t5_ar", 64'(obs_ar), 64'd1);
    repeat (3) begin
      idle(1'b1, 5'd0);
      check("t5_no_write", 64'(obs_we), 64'd0);
      check("t5_empty", 64'(obs_empty), 64'd1);
    end

    // Reset mid-drain
    cycle(1'b1, 5'd13, 64'hC2, 1'b1, 5'd12, 64'hC1, 1'b0, 5'd0, 5'd0);
    cycle(1'b1, 5'd14, 64'hC3, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
    pulse_reset();
    repeat (4) begin
      idle(1'b1, 5'd0);
      check("t6_no_stale", 64'(obs_we), 64'd0);
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ard, mrd;
      ard = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      mrd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      if (n == 1500) pulse_reset();
      cycle(1'($urandom_range(0, 1)), ard, {$urandom, $urandom},
            1'($urandom_range(0, 1)), mrd, {$urandom, $urandom},
            ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
